// File: rtl/tx_frame_seq_pkg.sv
// Shared types and constants for the TX frame sequencer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package tx_frame_seq_pkg;

    localparam int HDR_BYTES       = 14;
    localparam int ETH_MIN_PAYLOAD = 46;
    localparam int ETH_MAX_PAYLOAD = 1500;

    // Latched TX address; dst occupies the upper 48 bits.
    typedef struct packed {
        logic [47:0] dst;
        logic [47:0] src;
    } tx_addr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_HDR,
        ST_PAY,
        ST_GAP
    } state_t;

    // Clamp a requested payload length into [lo, hi].
    function automatic logic [10:0] clamp_len(input logic [10:0] len,
                                              input logic [10:0] lo,
                                              input logic [10:0] hi);
        logic [10:0] r;
        r = len;
        if (len < lo) r = lo;
        if (len > hi) r = hi;
        return r;
    endfunction

endpackage

// File: rtl/tx_byte_mux.sv
// Header byte selector: picks one of the 14 Ethernet header bytes by index.
// Latency: purely combinational.
// Backpressure: none; the caller holds byte_idx stable while stalled.
module tx_byte_mux
    import tx_frame_seq_pkg::*;
(
    input  logic [3:0]  byte_idx,
    input  tx_addr_t    addr,
    input  logic [10:0] len,
    output logic [7:0]  hdr_byte
);

    // Destination MAC, source MAC (both MSB first), then the 16-bit length field.
    always_comb begin
        hdr_byte = 8'h00;
        case (byte_idx)
            4'd0:    hdr_byte = addr.dst[47:40];
            4'd1:    hdr_byte = addr.dst[39:32];
            4'd2:    hdr_byte = addr.dst[31:24];
            4'd3:    hdr_byte = addr.dst[23:16];
            4'd4:    hdr_byte = addr.dst[15:8];
            4'd5:    hdr_byte = addr.dst[7:0];
            4'd6:    hdr_byte = addr.src[47:40];
            4'd7:    hdr_byte = addr.src[39:32];
            4'd8:    hdr_byte = addr.src[31:24];
            4'd9:    hdr_byte = addr.src[23:16];
            4'd10:   hdr_byte = addr.src[15:8];
            4'd11:   hdr_byte = addr.src[7:0];
            4'd12:   hdr_byte = {5'b00000, len[10:8]};
            4'd13:   hdr_byte = len[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/tx_frame_seq.sv
// TX frame sequencer: loads the TX address register, then streams dst/src/len header + counting payload, repeating with an IFG.
// Latency: addr_load 1 cycle after enable is sampled, first tvalid 3 cycles after; all AXI outputs come straight from flops.
// Backpressure: AXI-Stream; tdata/tlast/tvalid hold until tready. Optional frame counter under TX_FRAME_SEQ_CNT_EN.
module tx_frame_seq
    import tx_frame_seq_pkg::*;
#(
    parameter int IFG_CYCLES  = 12,
    parameter int MIN_PAYLOAD = ETH_MIN_PAYLOAD,
    parameter int MAX_PAYLOAD = ETH_MAX_PAYLOAD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [10:0] payload_len,
    output logic        addr_load,
    input  logic [95:0] tx_address,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        busy,
    output logic [15:0] frame_count
);

    localparam int          GW       = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(IFG_CYCLES - 1);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);
    localparam logic [3:0]  HDR_LAST = 4'(HDR_BYTES - 1);
    localparam logic [10:0] MIN_L    = 11'(MIN_PAYLOAD);
    localparam logic [10:0] MAX_L    = 11'(MAX_PAYLOAD);

    state_t        state, state_n;
    logic [3:0]    byte_idx, byte_idx_n;
    logic [10:0]   pay_idx, pay_idx_n;
    logic [GW-1:0] gap_cnt, gap_cnt_n;
    logic [10:0]   len_q, len_n;
    tx_addr_t      addr_q;
    tx_addr_t      addr_src;
    logic [7:0]    hdr_byte;
    logic [7:0]    tdata_n;
    logic          tvalid_n;
    logic          tlast_n;
    logic          hs;

    assign hs = m_axis_tvalid & m_axis_tready;

    // In WAIT the shadow is not yet loaded, so the first header byte comes from the live register.
    assign addr_src = (state == ST_WAIT) ? tx_addr_t'(tx_address) : addr_q;

    tx_byte_mux u_byte_mux (
        .byte_idx (byte_idx_n),
        .addr     (addr_src),
        .len      (len_q),
        .hdr_byte (hdr_byte)
    );

    // Next-state and index updates; indices only move on a handshake.
    always_comb begin
        state_n    = state;
        byte_idx_n = byte_idx;
        pay_idx_n  = pay_idx;
        gap_cnt_n  = gap_cnt;
        len_n      = len_q;
        case (state)
            ST_IDLE: begin
                if (enable) state_n = ST_LOAD;
            end
            ST_LOAD: begin
                len_n   = clamp_len(payload_len, MIN_L, MAX_L);
                state_n = ST_WAIT;
            end
            ST_WAIT: begin
                byte_idx_n = 4'd0;
                state_n    = ST_HDR;
            end
            ST_HDR: begin
                if (hs) begin
                    if (byte_idx == HDR_LAST) begin
                        pay_idx_n = 11'd0;
                        state_n   = ST_PAY;
                    end else begin
                        byte_idx_n = byte_idx + 4'd1;
                    end
                end
            end
            ST_PAY: begin
                if (hs) begin
                    if (m_axis_tlast) begin
                        gap_cnt_n = '0;
                        state_n   = ST_GAP;
                    end else begin
                        pay_idx_n = pay_idx + 11'd1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_n = enable ? ST_LOAD : ST_IDLE;
                end else begin
                    gap_cnt_n = gap_cnt + GAP_ONE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Values the AXI output flops take next, derived from the next state so the outputs are registered.
    always_comb begin
        tvalid_n = (state_n == ST_HDR) || (state_n == ST_PAY);
        tlast_n  = (state_n == ST_PAY) && (pay_idx_n == (len_q - 11'd1));
        tdata_n  = 8'h00;
        if (state_n == ST_HDR) begin
            tdata_n = hdr_byte;
        end else if (state_n == ST_PAY) begin
            tdata_n = pay_idx_n[7:0];
        end
    end

    // State, counters, shadow address and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            byte_idx      <= 4'd0;
            pay_idx       <= 11'd0;
            gap_cnt       <= '0;
            len_q         <= 11'd0;
            addr_q        <= '0;
            addr_load     <= 1'b0;
            busy          <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= 8'h00;
        end else begin
            state         <= state_n;
            byte_idx      <= byte_idx_n;
            pay_idx       <= pay_idx_n;
            gap_cnt       <= gap_cnt_n;
            len_q         <= len_n;
            if (state == ST_WAIT) addr_q <= tx_addr_t'(tx_address);
            addr_load     <= (state_n == ST_LOAD);
            busy          <= (state_n != ST_IDLE);
            m_axis_tvalid <= tvalid_n;
            m_axis_tlast  <= tlast_n;
            m_axis_tdata  <= tdata_n;
        end
    end

`ifdef TX_FRAME_SEQ_CNT_EN
    logic        frame_done;
    logic [15:0] frame_cnt_q;

    assign frame_done = (state == ST_PAY) && hs && m_axis_tlast;

    // Completed-frame counter; wraps from FFFF to 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_q <= 16'h0000;
        end else if (frame_done) begin
            frame_cnt_q <= frame_cnt_q + 16'h0001;
        end
    end

    assign frame_count = frame_cnt_q;
`else
    assign frame_count = 16'h0000;
`endif

endmodule

// File: tb/tb_tx_frame_seq.sv
`timescale 1ns/1ps
module tb_tx_frame_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [10:0] payload_len = 11'd0;
    logic        addr_load;
    logic [95:0] tx_address = 96'h0;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic        busy;
    logic [15:0] frame_count;

`ifdef TX_FRAME_SEQ_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    tx_frame_seq #(.IFG_CYCLES(12), .MIN_PAYLOAD(46), .MAX_PAYLOAD(1500)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .payload_len   (payload_len),
        .addr_load     (addr_load),
        .tx_address    (tx_address),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .frame_count   (frame_count)
    );

    always #5 clk = ~clk;

    // Model of the external TX address register: latches addr_next on the load strobe.
    logic [95:0] addr_next = 96'h0;
    always @(posedge clk) if (addr_load === 1'b1) tx_address <= addr_next;

    int cyc_now = 0;
    always @(posedge clk) cyc_now <= cyc_now + 1;

    int al_cnt = 0;
    int al_cyc = -1;
    int fv_cyc = -1;
    always @(negedge clk) begin
        if (addr_load === 1'b1) begin al_cnt++; al_cyc = cyc_now; end
        if (m_axis_tvalid === 1'b1 && fv_cyc < 0) fv_cyc = cyc_now;
    end

    logic [7:0] rx_bytes[$];
    logic [7:0] exp_bytes[$];
    int  rx_stall_err;
    int  rx_last_cnt;
    int  rx_last_cyc;
    bit  rx_timeout;
    int  first_bad;

    function automatic int byte_errs();
        int n = 0;
        first_bad = -1;
        for (int i = 0; i < exp_bytes.size(); i++) begin
            if (i >= rx_bytes.size() || rx_bytes[i] !== exp_bytes[i]) begin
                n++;
                if (first_bad < 0) first_bad = i;
            end
        end
        return n;
    endfunction

    function automatic logic [7:0] rx_at(input int i);
        if (i < rx_bytes.size()) return rx_bytes[i];
        return 8'hxx;
    endfunction

    task automatic build_exp(input logic [47:0] dst, input logic [47:0] src, input int plen);
        exp_bytes.delete();
        for (int i = 5; i >= 0; i--) exp_bytes.push_back(dst[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) exp_bytes.push_back(src[i*8 +: 8]);
        exp_bytes.push_back(8'((plen >> 8) & 255));
        exp_bytes.push_back(8'(plen & 255));
        for (int i = 0; i < plen; i++) exp_bytes.push_back(8'(i & 255));
    endtask

    // Receive one frame; called and returning on a negedge. mode 0: tready=1, 1: toggle, 2: toggle + 5-cycle hold at byte 13.
    task automatic rx_frame(input int mode, input int drop_at, input int budget);
        int cyc = 0;
        int hold = 0;
        bit held13 = 1'b0;
        bit stalled = 1'b0;
        bit tog = 1'b0;
        bit done = 1'b0;
        logic [7:0] pd = 8'h00;
        logic pl = 1'b0;
        rx_bytes.delete();
        rx_stall_err = 0; rx_timeout = 1'b0; rx_last_cnt = 0; rx_last_cyc = -1;
        while (!done) begin
            if (stalled && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== pd || m_axis_tlast !== pl))
                rx_stall_err++;
            if (mode == 0) begin
                m_axis_tready = 1'b1;
            end else begin
                tog = ~tog;
                m_axis_tready = tog;
                if (mode == 2 && !held13 && m_axis_tvalid === 1'b1 && rx_bytes.size() == 13) begin
                    held13 = 1'b1; hold = 5;
                end
                if (hold > 0) begin m_axis_tready = 1'b0; hold--; end
            end
            if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
                rx_bytes.push_back(m_axis_tdata);
                if (drop_at >= 0 && rx_bytes.size() == drop_at) enable = 1'b0;
                if (m_axis_tlast === 1'b1) begin rx_last_cnt++; rx_last_cyc = cyc_now; done = 1'b1; end
            end
            stalled = (m_axis_tvalid === 1'b1) && (m_axis_tready !== 1'b1);
            pd = m_axis_tdata; pl = m_axis_tlast;
            cyc++;
            if (!done && cyc > budget) begin rx_timeout = 1'b1; done = 1'b1; end
            @(negedge clk);
        end
        m_axis_tready = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        al_cnt = 0; fv_cyc = -1; al_cyc = -1;
    endtask

    task automatic test_reset();
        enable = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (addr_load !== 1'b0) begin failures++; $display("FAIL rst_addr_load: got %b want 0", addr_load); end
        checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL rst_tvalid: got %b want 0", m_axis_tvalid); end
        checks++; if (m_axis_tlast !== 1'b0) begin failures++; $display("FAIL rst_tlast: got %b want 0", m_axis_tlast); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (m_axis_tdata !== 8'h00) begin failures++; $display("FAIL rst_tdata: got %h want 00", m_axis_tdata); end
        checks++; if (frame_count !== 16'h0000) begin failures++; $display("FAIL rst_frame_count: got %h want 0000", frame_count); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        int en_cyc;
        int nb;
        do_reset();
        addr_next = {48'h0A0B0C0D0E0F, 48'h112233445566};
        payload_len = 11'd60;
        build_exp(48'h0A0B0C0D0E0F, 48'h112233445566, 60);
        enable = 1'b1; en_cyc = cyc_now;
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        payload_len = 11'd200;   // past LOAD: must not affect this frame
        rx_frame(0, -1, 500);
        repeat (20) @(negedge clk);
        nb = byte_errs();
        checks++; if (rx_timeout !== 1'b0) begin failures++; $display("FAIL basic_timeout: got %b want 0", rx_timeout); end
        checks++; if (rx_bytes.size() !== 74) begin failures++; $display("FAIL basic_len: got %0d want 74", rx_bytes.size()); end
        checks++; if (nb !== 0) begin failures++; $display("FAIL basic_bytes: %0d bad, first idx %0d got %h want %h", nb, first_bad, rx_at(first_bad), exp_bytes[first_bad]); end
        checks++; if (rx_last_cnt !== 1) begin failures++; $display("FAIL basic_tlast: got %0d want 1", rx_last_cnt); end
        checks++; if (al_cnt !== 1) begin failures++; $display("FAIL basic_addr_load_cnt: got %0d want 1", al_cnt); end
        checks++; if (al_cyc !== en_cyc + 1) begin failures++; $display("FAIL basic_load_latency: got %0d want %0d", al_cyc - en_cyc, 1); end
        checks++; if (fv_cyc !== en_cyc + 3) begin failures++; $display("FAIL basic_tvalid_latency: got %0d want %0d", fv_cyc - en_cyc, 3); end
        checks++; if (frame_count !== (CNT_EN ? 16'd1 : 16'd0)) begin failures++; $display("FAIL basic_frame_count: got %0d want %0d", frame_count, CNT_EN ? 1 : 0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_clamp();
        int nb;
        do_reset();
        addr_next = {48'hFFEEDDCCBBAA, 48'h010203040506};
        payload_len = 11'd10;
        build_exp(48'hFFEEDDCCBBAA, 48'h010203040506, 46);
        enable = 1'b1; @(negedge clk); enable = 1'b0;
        rx_frame(0, -1, 500);
        nb = byte_errs();
        checks++; if (rx_bytes.size() !== 60) begin failures++; $display("FAIL clamp_lo_len: got %0d want 60", rx_bytes.size()); end
        checks++; if (rx_at(12) !== 8'h00 || rx_at(13) !== 8'h2E) begin failures++; $display("FAIL clamp_lo_lenfield: got %h%h want 002e", rx_at(12), rx_at(13)); end
        checks++; if (nb !== 0) begin failures++; $display("FAIL clamp_lo_bytes: %0d bad, first idx %0d", nb, first_bad); end
        repeat (20) @(negedge clk);
        payload_len = 11'd1600;
        build_exp(48'hFFEEDDCCBBAA, 48'h010203040506, 1500);
        enable = 1'b1; @(negedge clk); enable = 1'b0;
        rx_frame(0, -1, 3000);
        nb = byte_errs();
        checks++; if (rx_timeout !== 1'b0) begin failures++; $display("FAIL clamp_hi_timeout: got %b want 0", rx_timeout); end
        checks++; if (rx_bytes.size() !== 1514) begin failures++; $display("FAIL clamp_hi_len: got %0d want 1514", rx_bytes.size()); end
        checks++; if (rx_at(12) !== 8'h05 || rx_at(13) !== 8'hDC) begin failures++; $display("FAIL clamp_hi_lenfield: got %h%h want 05dc", rx_at(12), rx_at(13)); end
        checks++; if (rx_at(14 + 255) !== 8'hFF || rx_at(14 + 256) !== 8'h00) begin failures++; $display("FAIL clamp_hi_wrap: got %h %h want ff 00", rx_at(269), rx_at(270)); end
        checks++; if (nb !== 0) begin failures++; $display("FAIL clamp_hi_bytes: %0d bad, first idx %0d", nb, first_bad); end
        repeat (20) @(negedge clk);
        checks++; if (frame_count !== (CNT_EN ? 16'd2 : 16'd0)) begin failures++; $display("FAIL clamp_frame_count: got %0d want %0d", frame_count, CNT_EN ? 2 : 0); end
    endtask

    task automatic test_backpressure();
        int nb;
        do_reset();
        addr_next = {48'h123456789ABC, 48'hDEF012345678};
        payload_len = 11'd50;
        build_exp(48'h123456789ABC, 48'hDEF012345678, 50);
        enable = 1'b1; @(negedge clk); enable = 1'b0;
        rx_frame(2, -1, 1000);
        nb = byte_errs();
        checks++; if (rx_timeout !== 1'b0) begin failures++; $display("FAIL bp_timeout: got %b want 0", rx_timeout); end
        checks++; if (rx_stall_err !== 0) begin failures++; $display("FAIL bp_stall_stable: got %0d changes want 0", rx_stall_err); end
        checks++; if (rx_bytes.size() !== 64) begin failures++; $display("FAIL bp_len: got %0d want 64", rx_bytes.size()); end
        checks++; if (nb !== 0) begin failures++; $display("FAIL bp_bytes: %0d bad, first idx %0d got %h want %h", nb, first_bad, rx_at(first_bad), exp_bytes[first_bad]); end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_continuous();
        int lc;
        int nb;
        do_reset();
        addr_next = {48'h0A0B0C0D0E0F, 48'h112233445566};
        payload_len = 11'd46;
        build_exp(48'h0A0B0C0D0E0F, 48'h112233445566, 46);
        enable = 1'b1;
        rx_frame(0, -1, 500);
        lc = rx_last_cyc;
        rx_frame(0, -1, 500);
        checks++; if (al_cyc - lc - 1 !== 12) begin failures++; $display("FAIL cont_ifg1: got %0d want 12", al_cyc - lc - 1); end
        lc = rx_last_cyc;
        rx_frame(0, -1, 500);
        enable = 1'b0;
        checks++; if (al_cyc - lc - 1 !== 12) begin failures++; $display("FAIL cont_ifg2: got %0d want 12", al_cyc - lc - 1); end
        nb = byte_errs();
        checks++; if (nb !== 0 || rx_timeout !== 1'b0) begin failures++; $display("FAIL cont_frame3_bytes: %0d bad timeout=%b want 0 0", nb, rx_timeout); end
        repeat (30) @(negedge clk);
        checks++; if (al_cnt !== 3) begin failures++; $display("FAIL cont_load_cnt: got %0d want 3", al_cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cont_busy: got %b want 0", busy); end
        checks++; if (frame_count !== (CNT_EN ? 16'd3 : 16'd0)) begin failures++; $display("FAIL cont_frame_count: got %0d want %0d", frame_count, CNT_EN ? 3 : 0); end
    endtask

    task automatic test_enable_drop();
        int nb;
        do_reset();
        addr_next = {48'h0A0B0C0D0E0F, 48'h112233445566};
        payload_len = 11'd60;
        build_exp(48'h0A0B0C0D0E0F, 48'h112233445566, 60);
        enable = 1'b1;
        rx_frame(0, -1, 500);
        rx_frame(0, 20, 500);
        nb = byte_errs();
        checks++; if (rx_bytes.size() !== 74 || nb !== 0) begin failures++; $display("FAIL drop_frame2: got len %0d bad %0d want 74 0", rx_bytes.size(), nb); end
        repeat (40) @(negedge clk);
        checks++; if (al_cnt !== 2) begin failures++; $display("FAIL drop_load_cnt: got %0d want 2", al_cnt); end
        checks++; if (busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL drop_idle: got busy=%b tvalid=%b want 0 0", busy, m_axis_tvalid); end
        checks++; if (frame_count !== (CNT_EN ? 16'd2 : 16'd0)) begin failures++; $display("FAIL drop_frame_count: got %0d want %0d", frame_count, CNT_EN ? 2 : 0); end
    endtask

    task automatic test_reset_mid();
        int nb;
        do_reset();
        addr_next = {48'h0A0B0C0D0E0F, 48'h112233445566};
        payload_len = 11'd60;
        enable = 1'b1; @(negedge clk); enable = 1'b0;
        m_axis_tready = 1'b1;
        repeat (25) @(negedge clk);
        checks++; if (m_axis_tvalid !== 1'b1) begin failures++; $display("FAIL mid_in_frame: got tvalid=%b want 1", m_axis_tvalid); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin failures++; $display("FAIL mid_abort: got tvalid=%b tlast=%b want 0 0", m_axis_tvalid, m_axis_tlast); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy: got %b want 0", busy); end
        checks++; if (frame_count !== 16'h0000) begin failures++; $display("FAIL mid_frame_count: got %0d want 0", frame_count); end
        al_cnt = 0;
        addr_next = {48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6};
        payload_len = 11'd48;
        build_exp(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 48);
        @(negedge clk);
        enable = 1'b1; @(negedge clk); enable = 1'b0;
        rx_frame(0, -1, 500);
        nb = byte_errs();
        checks++; if (rx_bytes.size() !== 62) begin failures++; $display("FAIL mid_restart_len: got %0d want 62", rx_bytes.size()); end
        checks++; if (nb !== 0) begin failures++; $display("FAIL mid_restart_bytes: %0d bad, first idx %0d got %h want %h", nb, first_bad, rx_at(first_bad), exp_bytes[first_bad]); end
        checks++; if (al_cnt !== 1) begin failures++; $display("FAIL mid_restart_load: got %0d want 1", al_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_backpressure();
        test_continuous();
        test_enable_drop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tx_frame_seq.md
Name: tx_frame_seq

Overview:
- Transmit-side sequencer for the pattern generator.
- Pulses the load strobe of the TX address register and reads back the latched 96-bit address.
- Streams one Ethernet frame byte-wise over AXI-Stream to the MAC TX client interface: destination MAC, source MAC, length/type, then an incrementing payload pattern.
- Repeats while enabled, with a programmable inter-frame gap.

Parameters:
- IFG_CYCLES, 12, idle cycles in GAP between frames (≥1)
- MIN_PAYLOAD, 46, lower clamp on payload length (bytes)
- MAX_PAYLOAD, 1500, upper clamp on payload length (bytes)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- enable  in  1  level; run frames back-to-back while high
- payload_len  in  11  requested payload bytes; sampled in LOAD
- addr_load  out  1  one-cycle strobe to the TX address register write enable
- tx_address  in  96  latched address from the register; dst = [95:48], src = [47:0]
- m_axis_tdata  out  8  frame byte
- m_axis_tvalid  out  1  byte valid
- m_axis_tready  in  1  MAC accepts byte
- m_axis_tlast  out  1  last byte of frame
- busy  out  1  high in any state except IDLE
- frame_count  out  16  completed frames (see Optional Feature)

Behaviour:
- Reset (rst_n low at posedge clk): state = IDLE.
  - addr_load, tvalid, tlast, busy = 0; tdata = 8'h00; frame_count = 0; all counters = 0.
  - Reset mid-frame aborts immediately with no tlast.
- States: IDLE, LOAD, WAIT, HDR, PAY, GAP.
- IDLE:
  - enable = 1 → LOAD.
- LOAD (1 cycle):
  - addr_load = 1.
  - Latch len_q = clamp(payload_len, MIN_PAYLOAD, MAX_PAYLOAD).
  - → WAIT.
- WAIT (1 cycle):
  - The register updates at the edge ending LOAD; tx_address is valid from this cycle.
  - Capture a shadow copy of tx_address.
  - → HDR with byte_idx = 0.
- HDR:
  - tvalid = 1; byte_idx 0..13.
  - Bytes 0–5: dst, MSB first (byte 0 = tx_address[95:88]).
  - Bytes 6–11: src, MSB first.
  - Byte 12 = len_q[10:8] zero-extended; byte 13 = len_q[7:0].
  - Index advances only on the tvalid & tready handshake. After the handshake on byte 13 → PAY with pay_idx = 0.
- PAY:
  - tdata = pay_idx[7:0] (wraps every 256 bytes).
  - tlast = 1 exactly when pay_idx == len_q − 1.
  - Handshake on the tlast byte → GAP; frame_count increments.
- GAP:
  - Counts IFG_CYCLES cycles with tvalid = 0.
  - Then → LOAD if enable = 1, else → IDLE.
- AXI rules:
  - Once tvalid is asserted, tdata, tlast and tvalid hold until tready.
  - tvalid never depends combinationally on tready.
  - Output registered; first header byte appears the cycle after WAIT.
- Latency: enable rising in IDLE → addr_load next cycle → first tvalid 3 cycles after enable is sampled.
- enable deasserting mid-frame: the frame completes in full; the block stops after GAP.
- payload_len changes mid-frame: ignored until the next LOAD.
- Clamping:
  - payload_len = 0 → 46.
  - payload_len = 2047 → 1500.
- Frame length on the wire = 14 + len_q bytes.
- frame_count wraps 16'hFFFF → 0.

Optional Feature:
- Macro: TX_FRAME_SEQ_CNT_EN.
  - Defined: frame_count is a 16-bit counter as above.
  - Undefined: frame_count is tied to 0 and no counter flops are generated.

Decomposition:
- Shared package holds:
  - the address struct (dst, src; 48 bits each);
  - the state enum;
  - constants HDR_BYTES = 14, ETH_MIN_PAYLOAD = 46, ETH_MAX_PAYLOAD = 1500.
- One sub-module: tx_byte_mux — combinational selection of the header byte from byte_idx, the shadow address and len_q. The FSM and counters stay in tx_frame_seq.

Test Plan:
- Basic frame:
  - Stimulus: dst = 0x0A0B0C0D0E0F, src = 0x112233445566, payload_len = 60, tready = 1, enable pulsed.
  - Response: one addr_load pulse; 74 bytes: 0A..0F, 11..66, 00, 3C, 00..3B; tlast on byte 74 only; frame_count = 1.
- Clamping:
  - payload_len = 10 → 60-byte frame, length bytes 00 2E.
  - payload_len = 1600 → 1514-byte frame, length bytes 05 DC.
  - At 1500-byte payload, data wraps FF → 00 at payload byte 256.
- Backpressure:
  - tready toggles 1/0 every cycle, plus held low for 5 cycles at byte 13.
  - tdata and tlast stable while stalled; no byte lost or duplicated.
- Continuous mode:
  - enable held high for 3 frames; exactly IFG_CYCLES = 12 idle cycles between tlast handshake and the next addr_load.
  - enable dropped mid-frame 2: frame 2 completes, no frame 3; frame_count = 2.
- Reset mid-payload:
  - rst_n low for 1 cycle.
  - Next cycle: tvalid = 0, busy = 0, frame_count = 0; a subsequent frame starts cleanly from header byte 0.
